// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Display timing generator for the 1024x768 world map. Free-running
//   horizontal/vertical counters drive the pixel coordinates consumed by the
//   painting stages. Sync, blanking and frame/line markers are registered and
//   decoded from the next-count value, so they describe the coordinates shown
//   in the same cycle.
//
// Ports
//   clock         in   pixel clock (65 MHz for the default timing)
//   reset         in   synchronous, active-high
//   pixel_column  out  [11:0] horizontal count, 0..H_TOTAL-1
//   pixel_row     out  [11:0] vertical count,   0..V_TOTAL-1
//   horiz_sync    out  horizontal sync, SYNC_POL level when active
//   vert_sync     out  vertical sync, SYNC_POL level when active
//   video_on      out  high only inside the visible region
//   frame_start   out  one-cycle pulse at count (0,0)
//   line_start    out  one-cycle pulse at every pixel_column == 0
//
// Build option
//   TIMING_ROM_ALIGN_EN : adds one register stage on the decoded outputs so
//   they lag the counters by one clock, matching block-ROM sprite latency.

module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FRONT  = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BACK   = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FRONT  = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BACK   = 29,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [11:0] pixel_column,
  output logic [11:0] pixel_row,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        video_on,
  output logic        frame_start,
  output logic        line_start
);

  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [11:0] H_VIS      = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS      = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [11:0] h_next;
  logic [11:0] v_next;

  logic hs_d, vs_d, vid_d, fs_d, ls_d;
  logic hs_q, vs_q, vid_q, fs_q, ls_q;

  // Next-count computation; the vertical counter only moves on a line wrap.
  always_comb begin
    h_next = pixel_column + 12'd1;
    v_next = pixel_row;
    if (pixel_column == H_LAST) begin
      h_next = '0;
      if (pixel_row == V_LAST) begin
        v_next = '0;
      end else begin
        v_next = pixel_row + 12'd1;
      end
    end
  end

  // Decode from the next count so the registered flags line up with the
  // counter value they are loaded alongside.
  always_comb begin
    vid_d = (h_next < H_VIS) && (v_next < V_VIS);
    hs_d  = ((h_next >= H_SYNC_BEG) && (h_next <= H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vs_d  = ((v_next >= V_SYNC_BEG) && (v_next <= V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    ls_d  = (h_next == '0);
    fs_d  = (h_next == '0) && (v_next == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_column <= H_LAST;
      pixel_row    <= V_LAST;
      hs_q         <= ~SYNC_POL;
      vs_q         <= ~SYNC_POL;
      vid_q        <= 1'b0;
      fs_q         <= 1'b0;
      ls_q         <= 1'b0;
    end else begin
      pixel_column <= h_next;
      pixel_row    <= v_next;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      vid_q        <= vid_d;
      fs_q         <= fs_d;
      ls_q         <= ls_d;
    end
  end

`ifdef TIMING_ROM_ALIGN_EN
  // Extra stage: decoded flags trail the coordinates by one clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      horiz_sync  <= ~SYNC_POL;
      vert_sync   <= ~SYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      horiz_sync  <= hs_q;
      vert_sync   <= vs_q;
      video_on    <= vid_q;
      frame_start <= fs_q;
      line_start  <= ls_q;
    end
  end
`else
  always_comb begin
    horiz_sync  = hs_q;
    vert_sync   = vs_q;
    video_on    = vid_q;
    frame_start = fs_q;
    line_start  = ls_q;
  end
`endif

endmodule
